// File: rtl/fp_mult_result_fifo.sv
// Result FIFO behind the combinational FP multiplier: product + {exc,ovf,unf} flags, sticky status,
// and optional saturating event counters (enable with macro FPM_RES_CNT_EN).
module fp_mult_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_exception,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_sticky,
  output logic [2:0]               sticky_flags,
  output logic [CNT_W-1:0]         cnt_total,
  output logic [CNT_W-1:0]         cnt_exc,
  output logic [CNT_W-1:0]         cnt_ovf,
  output logic [CNT_W-1:0]         cnt_unf
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned ENT_W = 35;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic             push, pop;
  logic             full_nxt, empty_nxt;
  logic [2:0]       in_flags;
  logic [2:0]       sticky_nxt;
  logic [ENT_W-1:0] head;

  assign in_flags = {in_exception, in_overflow, in_underflow};
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  // Next-state pointer arithmetic; status flags are registered from it.
  always_comb begin
    wr_ptr_nxt = wr_ptr + PTR_W'(push);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                 (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    sticky_nxt = (clr_sticky ? 3'b000 : sticky_flags) | (push ? in_flags : 3'b000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      level        <= '0;
      sticky_flags <= 3'b000;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      in_ready     <= !full_nxt;
      out_valid    <= !empty_nxt;
      level        <= wr_ptr_nxt - rd_ptr_nxt;
      sticky_flags <= sticky_nxt;
    end
  end

  // Storage carries no reset; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_flags, in_result};
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_result = out_valid ? head[31:0]  : 32'd0;
  assign out_flags  = out_valid ? head[34:32] : 3'b000;

`ifdef FPM_RES_CNT_EN
  // Saturating increment; a clear in the same cycle restarts from zero before counting.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic clr, input logic inc);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : v;
    return (inc && (base != '1)) ? base + CNT_W'(1) : base;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_total <= '0;
      cnt_exc   <= '0;
      cnt_ovf   <= '0;
      cnt_unf   <= '0;
    end else begin
      cnt_total <= sat_inc(cnt_total, clr_sticky, push);
      cnt_exc   <= sat_inc(cnt_exc,   clr_sticky, push & in_exception);
      cnt_ovf   <= sat_inc(cnt_ovf,   clr_sticky, push & in_overflow);
      cnt_unf   <= sat_inc(cnt_unf,   clr_sticky, push & in_underflow);
    end
  end
`else
  assign cnt_total = '0;
  assign cnt_exc   = '0;
  assign cnt_ovf   = '0;
  assign cnt_unf   = '0;
`endif

endmodule

// File: tb/tb_fp_mult_result_fifo.sv
// Bench for fp_mult_result_fifo: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_fp_mult_result_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_result = 32'd0;
  logic             in_exception = 1'b0;
  logic             in_overflow = 1'b0;
  logic             in_underflow = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [2:0]       out_flags;
  logic [LVL_W-1:0] level;
  logic             clr_sticky = 1'b0;
  logic [2:0]       sticky_flags;
  logic [CNT_W-1:0] cnt_total, cnt_exc, cnt_ovf, cnt_unf;

  fp_mult_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_exception(in_exception), .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .level(level), .clr_sticky(clr_sticky), .sticky_flags(sticky_flags),
    .cnt_total(cnt_total), .cnt_exc(cnt_exc), .cnt_ovf(cnt_ovf), .cnt_unf(cnt_unf)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: a queue of {flags,result} words plus sticky bits and saturating counts.
  logic [34:0] mq[$];
  logic [2:0]  m_sticky = 3'b000;
  int          m_tot = 0, m_exc = 0, m_ovf = 0, m_unf = 0;
  localparam int CMAX = (1 << CNT_W) - 1;

  function automatic int sat(input int v, input bit clr, input bit inc);
    int b;
    b = clr ? 0 : v;
    return (inc && b < CMAX) ? b + 1 : b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_sticky = 3'b000;
      m_tot = 0; m_exc = 0; m_ovf = 0; m_unf = 0;
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() > 0);
      if (clr_sticky) m_sticky = 3'b000;
      if (do_push) m_sticky |= {in_exception, in_overflow, in_underflow};
      m_tot = sat(m_tot, clr_sticky, do_push);
      m_exc = sat(m_exc, clr_sticky, do_push && in_exception);
      m_ovf = sat(m_ovf, clr_sticky, do_push && in_overflow);
      m_unf = sat(m_unf, clr_sticky, do_push && in_underflow);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({in_exception, in_overflow, in_underflow, in_result});
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [34:0] h;
      h = (mq.size() > 0) ? mq[0] : 35'd0;
      chk("in_ready",   64'(in_ready),     64'(mq.size() < DEPTH));
      chk("out_valid",  64'(out_valid),    64'(mq.size() > 0));
      chk("level",      64'(level),        64'(mq.size()));
      chk("out_result", 64'(out_result),   64'(h[31:0]));
      chk("out_flags",  64'(out_flags),    64'(h[34:32]));
      chk("sticky",     64'(sticky_flags), 64'(m_sticky));
`ifdef FPM_RES_CNT_EN
      chk("cnt_total",  64'(cnt_total),    64'(m_tot));
      chk("cnt_exc",    64'(cnt_exc),      64'(m_exc));
      chk("cnt_ovf",    64'(cnt_ovf),      64'(m_ovf));
      chk("cnt_unf",    64'(cnt_unf),      64'(m_unf));
`else
      chk("cnt_all",    64'({cnt_total, cnt_exc, cnt_ovf, cnt_unf}), 64'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] r, input logic [2:0] f);
    in_valid = v;
    in_result = r;
    {in_exception, in_overflow, in_underflow} = f;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    set_in(1'b0, 32'd0, 3'b000);
    for (int i = 0; i < 2 * DEPTH && out_valid; i++) tick();
    chk("drain_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset values, observed while reset is held.
    #2 rst_n = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("rst_in_ready",  64'(in_ready),     64'd1);
    chk("rst_out_valid", 64'(out_valid),    64'd0);
    chk("rst_level",     64'(level),        64'd0);
    chk("rst_sticky",    64'(sticky_flags), 64'd0);
    chk("rst_out_result",64'(out_result),   64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Three words in with no pop, then drain in order.
    set_in(1'b1, 32'h4000_0000, 3'b000); tick();
    set_in(1'b1, 32'h3F80_0000, 3'b000); tick();
    set_in(1'b1, 32'hC040_0000, 3'b000); tick();
    set_in(1'b0, 32'd0, 3'b000);
    chk("t1_level3", 64'(level), 64'd3);
    chk("t1_head0", 64'(out_result), 64'h4000_0000);
    out_ready = 1'b1;
    tick(); chk("t1_head1", 64'(out_result), 64'h3F80_0000);
    tick(); chk("t1_head2", 64'(out_result), 64'hC040_0000);
    tick(); chk("t1_level0", 64'(level), 64'd0);
    chk("t1_empty_result", 64'(out_result), 64'd0);
    out_ready = 1'b0;

    // Fill to DEPTH, hold a fifth word against a full FIFO, then pop one.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'h1000_0000 + 32'(i), 3'b000);
      tick();
    end
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    set_in(1'b1, 32'hDEAD_BEEF, 3'b001);
    tick(); tick(); tick();
    chk("t2_held_level", 64'(level), 64'd4);
    chk("t2_held_head", 64'(out_result), 64'h1000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_ready_after_pop", 64'(in_ready), 64'd1);
    chk("t2_level_after_pop", 64'(level), 64'd3);
    tick();
    set_in(1'b0, 32'd0, 3'b000);
    chk("t2_fifth_in", 64'(level), 64'd4);
    drain();

    // Streaming push+pop across several pointer wraps.
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      set_in(1'b1, $urandom, 3'b000);
      tick();
      chk("t3_level1", 64'(level), 64'd1);
    end
    drain();

    // Sticky set, then clear together with a new flagged push.
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    set_in(1'b1, 32'h7F80_0000, 3'b100); tick();
    chk("t4_sticky_exc", 64'(sticky_flags), 64'b100);
    chk("t4_flags", 64'(out_flags), 64'b100);
    clr_sticky = 1'b1;
    set_in(1'b1, 32'h7F80_0000, 3'b010); tick();
    clr_sticky = 1'b0;
    set_in(1'b0, 32'd0, 3'b000);
    chk("t4_sticky_ovf", 64'(sticky_flags), 64'b010);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 99) < 60), $urandom, 3'($urandom));
      out_ready  = 1'($urandom_range(0, 99) < 50);
      clr_sticky = 1'($urandom_range(0, 99) < 5);
      tick();
    end
    clr_sticky = 1'b0;
    drain();

    // Twenty underflow words through a streaming FIFO; counters saturate.
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 32'h0000_0001 + 32'(i), 3'b001);
      tick();
    end
    drain();
`ifdef FPM_RES_CNT_EN
    chk("t6_cnt_unf", 64'(cnt_unf), 64'hF);
    chk("t6_cnt_total", 64'(cnt_total), 64'hF);
    chk("t6_cnt_exc", 64'(cnt_exc), 64'd0);
`else
    chk("t6_cnt_unf", 64'(cnt_unf), 64'd0);
    chk("t6_cnt_total", 64'(cnt_total), 64'd0);
    chk("t6_cnt_exc", 64'(cnt_exc), 64'd0);
`endif

    // Asynchronous reset with three entries held.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'hABC0_0000 + 32'(i), 3'b110);
      tick();
    end
    set_in(1'b0, 32'd0, 3'b000);
    chk("t5_pre_level", 64'(level), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_level", 64'(level), 64'd0);
    chk("t5_async_sticky", 64'(sticky_flags), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
